// File: rtl/accum_multi.sv
// Multi-channel accumulator with a request/response handshake: one request is
// accepted in IDLE, the updated channel value is reported from RESP.
module accum_multi #(
    parameter int unsigned ACCUM_WIDTH = 16,
    parameter int unsigned ADD_WIDTH   = 8,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SIGNED      = 0,
    parameter int unsigned SATURATE    = 0,
    localparam int unsigned CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHW-1:0]         in_ch,
    input  logic [1:0]             in_op,
    input  logic [ADD_WIDTH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHW-1:0]         out_ch,
    output logic [ACCUM_WIDTH-1:0] out_accum,
    output logic                   out_ovf,
    output logic                   out_err,
    output logic [NUM_CH-1:0]      ovf_flags
);

    localparam int unsigned MSB = ACCUM_WIDTH - 1;
    localparam logic [ACCUM_WIDTH-1:0] SAT_HI =
        (SIGNED != 0) ? ({ACCUM_WIDTH{1'b1}} >> 1) : {ACCUM_WIDTH{1'b1}};
    localparam logic [ACCUM_WIDTH-1:0] SAT_LO =
        (SIGNED != 0) ? ~({ACCUM_WIDTH{1'b1}} >> 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACCUM_WIDTH-1:0] acc_q [NUM_CH];
    logic [ACCUM_WIDTH-1:0] acc_d [NUM_CH];
    logic [NUM_CH-1:0]      ovf_q, ovf_d;
    logic [CHW-1:0]         out_ch_q, out_ch_d;
    logic [ACCUM_WIDTH-1:0] out_accum_q, out_accum_d;
    logic                   out_ovf_q, out_ovf_d;
    logic                   out_err_q, out_err_d;

    logic                   accept;
    logic                   ch_ok;
    logic [ACCUM_WIDTH-1:0] cur_acc;
    logic [ACCUM_WIDTH-1:0] ext;
    logic [ACCUM_WIDTH:0]   sum;
    logic [ACCUM_WIDTH:0]   diff;
    logic [ACCUM_WIDTH-1:0] raw;
    logic [ACCUM_WIDTH-1:0] res;
    logic                   op_ovf;

    // in_ready is held low while reset is asserted, even though the FSM sits in IDLE
    assign in_ready  = reset_l & (state_q == IDLE);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == RESP);
    assign out_ch    = out_ch_q;
    assign out_accum = out_accum_q;
    assign out_ovf   = out_ovf_q;
    assign out_err   = out_err_q;
    assign ovf_flags = ovf_q;

    // Datapath: operand extension, raw result, overflow detection and clamping
    always_comb begin
        ch_ok   = (32'(in_ch) < NUM_CH);
        cur_acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CHW'(i)) cur_acc = acc_q[i];
        end
        if (SIGNED != 0) ext = ACCUM_WIDTH'($signed(in_data));
        else             ext = ACCUM_WIDTH'(in_data);
        sum    = {1'b0, cur_acc} + {1'b0, ext};
        diff   = {1'b0, cur_acc} - {1'b0, ext};
        raw    = '0;
        op_ovf = 1'b0;
        case (in_op)
            2'b00: begin
                raw    = sum[MSB:0];
                op_ovf = (SIGNED != 0)
                       ? ((cur_acc[MSB] == ext[MSB]) && (raw[MSB] != cur_acc[MSB]))
                       : sum[ACCUM_WIDTH];
            end
            2'b01: begin
                raw    = diff[MSB:0];
                op_ovf = (SIGNED != 0)
                       ? ((cur_acc[MSB] != ext[MSB]) && (raw[MSB] != cur_acc[MSB]))
                       : diff[ACCUM_WIDTH];
            end
            2'b10:   raw = ext;
            default: raw = '0;
        endcase
        res = raw;
        // Signed overflow direction follows the sign of the operand already held
        if (op_ovf && (SATURATE != 0)) begin
            if (SIGNED != 0) res = cur_acc[MSB] ? SAT_LO : SAT_HI;
            else             res = (in_op == 2'b00) ? SAT_HI : SAT_LO;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_ch_d    = out_ch_q;
        out_accum_d = out_accum_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = RESP;
                    out_ch_d = in_ch;
                    if (ch_ok) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (in_ch == CHW'(i)) begin
                                acc_d[i] = res;
                                ovf_d[i] = in_op[1] ? 1'b0 : (ovf_q[i] | op_ovf);
                            end
                        end
                        out_accum_d = res;
                        out_ovf_d   = op_ovf;
                        out_err_d   = 1'b0;
                    end else begin
                        out_accum_d = '0;
                        out_ovf_d   = 1'b0;
                        out_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            ovf_q       <= '0;
            out_ch_q    <= '0;
            out_accum_q <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            out_ch_q    <= out_ch_d;
            out_accum_q <= out_accum_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
        end
    end

endmodule

// File: tb/tb_accum_multi.sv
// Bench for accum_multi: an unsigned wrapping 4-channel instance and a signed
// saturating 3-channel instance share one stimulus stream.
module tb_accum_multi;

    localparam int unsigned CHW = 2;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic           clk;
    logic           reset_l;
    logic           in_valid;
    logic           out_ready;
    logic [CHW-1:0] in_ch;
    logic [1:0]     in_op;
    logic [7:0]     in_data;

    logic           a_in_ready, a_out_valid, a_out_ovf, a_out_err;
    logic [CHW-1:0] a_out_ch;
    logic [15:0]    a_out_accum;
    logic [3:0]     a_ovf_flags;
    logic           b_in_ready, b_out_valid, b_out_ovf, b_out_err;
    logic [CHW-1:0] b_out_ch;
    logic [15:0]    b_out_accum;
    logic [2:0]     b_ovf_flags;

    int n_cmp;
    int n_err;

    // Reference state: [0] unsigned wrap, 4 channels; [1] signed saturate, 3 channels
    logic [15:0] m_acc  [2][4];
    logic        m_flag [2][4];
    logic [15:0] e_acc  [2];
    logic        e_ovf  [2];
    logic        e_err  [2];
    logic [1:0]  e_ch;

    accum_multi #(.ACCUM_WIDTH(16), .ADD_WIDTH(8), .NUM_CH(4), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ch(in_ch), .in_op(in_op), .in_data(in_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_ch(a_out_ch), .out_accum(a_out_accum),
        .out_ovf(a_out_ovf), .out_err(a_out_err), .ovf_flags(a_ovf_flags)
    );

    accum_multi #(.ACCUM_WIDTH(16), .ADD_WIDTH(8), .NUM_CH(3), .SIGNED(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ch(in_ch), .in_op(in_op), .in_data(in_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_ch(b_out_ch), .out_accum(b_out_accum),
        .out_ovf(b_out_ovf), .out_err(b_out_err), .ovf_flags(b_ovf_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_acc[k][i]  = '0;
                m_flag[k][i] = 1'b0;
            end
    endtask

    function automatic logic [3:0] flags_of(input int k);
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = m_flag[k][i];
        return f;
    endfunction

    // Plain integer arithmetic on the mathematical value, then range check
    task automatic model_step(input int k, input logic [1:0] ch, input logic [1:0] op,
                              input logic [7:0] d);
        int     num_ch;
        bit     sgn;
        longint a, x, r, lo, hi;
        bit     ovf;
        num_ch = (k == 0) ? 4 : 3;
        sgn    = (k == 1);
        if (int'(ch) >= num_ch) begin
            e_acc[k] = '0; e_ovf[k] = 1'b0; e_err[k] = 1'b1;
            return;
        end
        a = longint'(m_acc[k][ch]);
        x = longint'(d);
        if (sgn && a >= 32768) a = a - 65536;
        if (sgn && x >= 128)   x = x - 256;
        lo = sgn ? -32768 : 0;
        hi = sgn ? 32767 : 65535;
        case (op)
            OP_ADD:  r = a + x;
            OP_SUB:  r = a - x;
            OP_LOAD: r = x;
            default: r = 0;
        endcase
        ovf = (op[1] == 1'b0) && (r < lo || r > hi);
        if (ovf && sgn) r = (r > hi) ? hi : lo;
        m_acc[k][ch] = 16'(r);
        m_flag[k][ch] = op[1] ? 1'b0 : (m_flag[k][ch] | ovf);
        e_acc[k] = 16'(r);
        e_ovf[k] = ovf;
        e_err[k] = 1'b0;
    endtask

    task automatic check_resp(input string ph);
        logic [3:0] fa, fb;
        fa = flags_of(0);
        fb = flags_of(1);
        chk({ph, ":a_valid"}, 32'(a_out_valid), 1);
        chk({ph, ":a_ready"}, 32'(a_in_ready), 0);
        chk({ph, ":a_ch"},    32'(a_out_ch), 32'(e_ch));
        chk({ph, ":a_accum"}, 32'(a_out_accum), 32'(e_acc[0]));
        chk({ph, ":a_ovf"},   32'(a_out_ovf), 32'(e_ovf[0]));
        chk({ph, ":a_err"},   32'(a_out_err), 32'(e_err[0]));
        chk({ph, ":a_flags"}, 32'(a_ovf_flags), 32'(fa));
        chk({ph, ":b_valid"}, 32'(b_out_valid), 1);
        chk({ph, ":b_ready"}, 32'(b_in_ready), 0);
        chk({ph, ":b_ch"},    32'(b_out_ch), 32'(e_ch));
        chk({ph, ":b_accum"}, 32'(b_out_accum), 32'(e_acc[1]));
        chk({ph, ":b_ovf"},   32'(b_out_ovf), 32'(e_ovf[1]));
        chk({ph, ":b_err"},   32'(b_out_err), 32'(e_err[1]));
        chk({ph, ":b_flags"}, 32'(b_ovf_flags), 32'(fb[2:0]));
    endtask

    // Present a request in IDLE; returns one cycle after acceptance with RESP checked
    task automatic issue(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_ch = ch; in_op = op; in_data = d; out_ready = 1'b0;
        chk("a_ready_idle", 32'(a_in_ready), 1);
        chk("b_ready_idle", 32'(b_in_ready), 1);
        model_step(0, ch, op, d);
        model_step(1, ch, op, d);
        e_ch = ch;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_resp("resp");
    endtask

    // Hold the response for `stall` cycles with a stray request pending, then release
    task automatic release_resp(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_ch    = 2'($urandom);
            in_op    = 2'($urandom);
            in_data  = 8'($urandom);
            check_resp("hold");
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("a_valid_after", 32'(a_out_valid), 0);
        chk("b_valid_after", 32'(b_out_valid), 0);
    endtask

    task automatic xact(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] d,
                        input int stall);
        issue(ch, op, d);
        release_resp(stall);
    endtask

    initial begin
        int r;
        logic [1:0] op;
        n_cmp = 0; n_err = 0;
        reset_l = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ch = '0; in_op = '0; in_data = '0;
        model_reset();
        #1;
        chk("rst_a_valid", 32'(a_out_valid), 0);
        chk("rst_a_ready", 32'(a_in_ready), 0);
        chk("rst_a_accum", 32'(a_out_accum), 0);
        chk("rst_a_flags", 32'(a_ovf_flags), 0);
        chk("rst_b_valid", 32'(b_out_valid), 0);
        chk("rst_b_ready", 32'(b_in_ready), 0);
        repeat (2) @(negedge clk);
        reset_l = 1'b1;

        // Three ADDs of 5 on channel 0
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, OP_ADD, 8'h05);
            chk("add5_accum", 32'(a_out_accum), 32'(5 * (i + 1)));
            chk("add5_ovf", 32'(a_out_ovf), 0);
            release_resp(0);
        end

        // Unsigned wrap on channel 1
        xact(2'd1, OP_LOAD, 8'hFF, 0);
        for (int i = 0; i < 255; i++) xact(2'd1, OP_ADD, 8'hFF, 0);
        chk("wrap_ff00", 32'(a_out_accum), 'hFF00);
        issue(2'd1, OP_ADD, 8'hFF);
        chk("wrap_ffff", 32'(a_out_accum), 'hFFFF);
        release_resp(0);
        issue(2'd1, OP_ADD, 8'h01);
        chk("wrap_zero", 32'(a_out_accum), 0);
        chk("wrap_ovf", 32'(a_out_ovf), 1);
        chk("wrap_flag_set", 32'(a_ovf_flags[1]), 1);
        release_resp(1);
        issue(2'd1, OP_CLR, 8'h00);
        chk("clr_flag", 32'(a_ovf_flags[1]), 0);
        release_resp(0);

        // Signed negative clamp on channel 2
        for (int i = 0; i < 300; i++) xact(2'd2, OP_SUB, 8'h7F, 0);
        issue(2'd2, OP_SUB, 8'h7F);
        chk("sat_min", 32'(b_out_accum), 'h8000);
        chk("sat_min_ovf", 32'(b_out_ovf), 1);
        release_resp(0);
        issue(2'd2, OP_ADD, 8'h80);
        chk("sat_min_add", 32'(b_out_accum), 'h8000);
        chk("sat_min_add_ovf", 32'(b_out_ovf), 1);
        release_resp(0);

        // Signed positive clamp on channel 0
        xact(2'd0, OP_LOAD, 8'h7F, 0);
        for (int i = 0; i < 300; i++) xact(2'd0, OP_ADD, 8'h7F, 0);
        issue(2'd0, OP_ADD, 8'h7F);
        chk("sat_max", 32'(b_out_accum), 'h7FFF);
        chk("sat_max_flag", 32'(b_ovf_flags[0]), 1);
        release_resp(0);

        // Backpressure on channel 3 (out of range for the 3-channel instance)
        issue(2'd3, OP_ADD, 8'h01);
        chk("bp_accum", 32'(a_out_accum), 1);
        chk("err_flag", 32'(b_out_err), 1);
        chk("err_accum", 32'(b_out_accum), 0);
        release_resp(5);
        for (int c = 0; c < 3; c++) xact(2'(c), OP_ADD, 8'h00, 0);

        // Random traffic with random response stalls
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (r < 4) ? OP_ADD : (r < 7) ? OP_SUB : (r < 9) ? OP_LOAD : OP_CLR;
            xact(2'($urandom_range(0, 3)), op, 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while a response is pending
        issue(2'd0, OP_LOAD, 8'h10);
        chk("pre_rst_accum", 32'(a_out_accum), 'h0010);
        #2;
        reset_l = 1'b0;
        #1;
        model_reset();
        chk("arst_a_valid", 32'(a_out_valid), 0);
        chk("arst_b_valid", 32'(b_out_valid), 0);
        chk("arst_a_ready", 32'(a_in_ready), 0);
        chk("arst_a_accum", 32'(a_out_accum), 0);
        chk("arst_b_flags", 32'(b_ovf_flags), 0);
        @(negedge clk);
        reset_l = 1'b1;
        issue(2'd0, OP_ADD, 8'h01);
        chk("post_rst_a", 32'(a_out_accum), 'h0001);
        chk("post_rst_b", 32'(b_out_accum), 'h0001);
        release_resp(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
